// File: rtl/fnd_scan_ctrl.sv
// Scan controller for the 4-digit FND display. It drives the digit-mux select,
// the one-hot common lines and a per-digit blank flag, with dead time and leading-zero blanking.
module fnd_scan_ctrl #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEAD_CYC       = 0,
  parameter bit ACTIVE_LOW_COM = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic [15:0] i_value,
  input  logic        i_blank_lz,
  output logic [1:0]  o_sel,
  output logic [3:0]  o_com,
  output logic        o_blank,
  output logic        o_tick
);

  localparam int              CW      = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]   CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [3:0]      COM_OFF = ACTIVE_LOW_COM ? 4'b1111 : 4'b0000;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sel;
  logic [3:0]    r_com;
  logic          r_blank;
  logic          r_tick;

  logic          w_wrap;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_sel_nxt;
  logic [3:0]    w_lz_vec;
  logic          w_blank_nxt;
  logic          w_slot_live;
  logic [3:0]    w_onehot;
  logic [3:0]    w_com_nxt;

  // The registered outputs are computed from the next-state sel and count,
  // so o_com/o_blank line up with the o_sel value shown in the same cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_wrap      = i_en && (r_cnt == CNT_MAX);
    w_cnt_nxt   = r_cnt;
    if (i_en) w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
    w_sel_nxt   = w_wrap ? r_sel + 2'd1 : r_sel;

    // A digit is a leading zero only if it and every digit above it are zero.
    w_lz_vec[3] = i_blank_lz && (i_value[15:12] == 4'h0);
    w_lz_vec[2] = w_lz_vec[3] && (i_value[11:8] == 4'h0);
    w_lz_vec[1] = w_lz_vec[2] && (i_value[7:4]  == 4'h0);
    w_lz_vec[0] = 1'b0;
    w_blank_nxt = w_lz_vec[w_sel_nxt];

    w_slot_live = int'(w_cnt_nxt) >= DEAD_CYC;
    w_onehot    = 4'b0001 << w_sel_nxt;
    w_com_nxt   = COM_OFF;
    if (i_en && w_slot_live && !w_blank_nxt)
      w_com_nxt = ACTIVE_LOW_COM ? ~w_onehot : w_onehot;
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    if (i_reset) begin
      r_cnt   <= '0;
      r_sel   <= 2'd0;
      r_com   <= COM_OFF;
      r_blank <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_sel  <= w_sel_nxt;
      r_com  <= w_com_nxt;
      r_tick <= w_wrap;
      if (i_en) r_blank <= w_blank_nxt;
    end
  end

  assign o_sel   = r_sel;
  assign o_com   = r_com;
  assign o_blank = r_blank;
  assign o_tick  = r_tick;

endmodule
